pair_queue: RTL and testbench
=============================

Name: pair_queue

Overview:
- Downstream neighbour of the particle filter stage.
- Consumes the 193-bit filter result word {reject, reference[95:0], neighbor[95:0]}.
  - Discards rejected pairs.
  - Buffers accepted pairs in a FIFO.
  - Presents them to the force pipeline over a valid/ready handshake.
- Provides back-pressure (in_stall) to the pair generator, per-timestep accept/reject counters, and a start/flush/done sequence for the timestep controller.

Parameters:
- DEPTH, 16: FIFO entries; power of two, at least 4.
- AF_MARGIN, 4: in_stall asserts when occupancy >= DEPTH-AF_MARGIN; must be less than DEPTH.
- CNT_W, 16: width of the accepted and rejected counters.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a timestep.
- flush  in  1  one-cycle pulse; no further input this timestep, drain the FIFO.
- in_pair  in  193  filter output; bit 192 = reject, [191:96] = reference xyz fp32, [95:0] = neighbor xyz fp32.
- in_valid  in  1  in_pair is meaningful this cycle.
- in_stall  out  1  almost-full back-pressure to the pair generator.
- out_ref  out  96  reference position of the head pair.
- out_nbr  out  96  neighbor position of the head pair.
- out_valid  out  1  head pair is available.
- out_ready  in  1  force pipeline accepts the head pair.
- busy  out  1  state is RUN or DRAIN.
- done  out  1  one-cycle pulse when the drain completes.
- accepted_count  out  CNT_W  pairs written this timestep.
- rejected_count  out  CNT_W  pairs discarded by the reject bit this timestep.
- overflow  out  1  sticky; a valid non-rejected pair was lost because the FIFO was full.

Behaviour:
- Reset values:
  - State IDLE.
  - Read/write pointers and occupancy = 0.
  - out_valid, in_stall, busy, done, overflow = 0.
  - Both counters = 0.
  - out_ref and out_nbr are don't-care while out_valid = 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start. Entering RUN clears both counters and overflow; FIFO contents are retained.
  - RUN -> DRAIN on flush. The in_valid word in the flush cycle is still processed.
  - DRAIN -> DONE when occupancy = 0, checked after that cycle's pop.
  - DONE -> IDLE unconditionally. done = 1 only in the DONE cycle.
  - start is ignored outside IDLE. flush is ignored outside RUN.
  - start and flush together in IDLE: start is taken, flush is ignored.
- Input qualification (RUN only; in_valid is ignored in IDLE, DRAIN and DONE):
  - in_valid & in_pair[192] = 1: rejected_count += 1 (saturating); nothing is written.
  - in_valid & in_pair[192] = 0: the pair is written if occupancy < DEPTH, or if a pop occurs in the same cycle (occupancy = DEPTH, out_valid & out_ready). Then accepted_count += 1 (saturating).
  - Otherwise the pair is dropped: overflow <= 1, and accepted_count is unchanged.
- FIFO:
  - First-word-fall-through; registered occupancy and pointers.
  - Pointers wrap modulo DEPTH.
  - out_valid = (occupancy != 0). out_ref and out_nbr are driven from mem[rd_ptr].
  - A pop occurs when out_valid & out_ready. The pop works in any state, including IDLE.
  - Push-to-visible latency: a pair written at edge k appears at the head in the cycle after edge k when the FIFO was empty. Ordering is strict FIFO.
  - Simultaneous push and pop leaves occupancy unchanged, including when empty (no bypass) and when full.
- in_stall:
  - Registered.
  - Equals (occupancy_next >= DEPTH-AF_MARGIN).
  - Forced 0 outside RUN.
- Counters:
  - Saturate at all-ones.
  - Hold value in IDLE, DRAIN and DONE so the controller can read them after done.
- Reset mid-operation: returns immediately to reset values. FIFO contents are discarded, and no done pulse is issued.
- Data is passed through bit-exact; no arithmetic is performed on positions.

Test Plan:
- Basic pass-through:
  - Stimulus: reset, start, then 3 words with reject = 0 (ref = 0x3F800000_40000000_40400000, nbr = 0x0…01, 02, 03), out_ready = 1.
  - Required: out_valid 1 cycle after each push; pairs in order; accepted_count = 3, rejected_count = 0.
- Rejection:
  - Stimulus: 5 words alternating reject = 1/0/1/0/1.
  - Required: only the 2 reject = 0 pairs emerge; accepted_count = 2, rejected_count = 3; overflow = 0.
- Full and back-pressure:
  - Stimulus: DEPTH = 16, AF_MARGIN = 4, out_ready = 0, push 17 valid pairs.
  - Required: in_stall = 1 after the 12th push; pairs 1–16 stored; the 17th is dropped with overflow = 1 and accepted_count = 16.
- Full with simultaneous pop:
  - Stimulus: FIFO at 16 entries, out_ready = 1 and a valid push in the same cycle.
  - Required: push accepted; occupancy stays 16; overflow unchanged; ordering preserved.
- Flush and drain:
  - Stimulus: 4 pairs queued, flush with out_ready = 0 for 3 cycles, then 1; in_valid driven during DRAIN.
  - Required: DRAIN input ignored; busy = 1 throughout; 4 pairs emitted; done is a single pulse the cycle after occupancy reaches 0; busy = 0 after; counters unchanged.
- Reset mid-run:
  - Stimulus: assert rst with 6 entries queued in RUN.
  - Required: next cycle out_valid = 0, counters = 0, state IDLE, no done pulse; a subsequent start works normally.

Source files
------------

// File: rtl/pair_queue.sv
// Pair queue between the particle filter and the force pipeline: drops rejected
// pairs, buffers accepted ones in a FWFT FIFO and sequences start/flush/done.
module pair_queue #(
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [192:0]     in_pair,
  input  logic             in_valid,
  output logic             in_stall,
  output logic [95:0]      out_ref,
  output logic [95:0]      out_nbr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] accepted_count,
  output logic [CNT_W-1:0] rejected_count,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam logic [OW-1:0] FULL_C = OW'(DEPTH);
  localparam logic [OW-1:0] AF_C   = OW'(DEPTH - AF_MARGIN);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [OW-1:0]    occ_q, occ_d;
  logic [191:0]     mem_q [DEPTH];
  logic             in_stall_q, busy_q, done_q;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] acc_q, acc_d, rej_q, rej_d;
  logic             pop, take, push, drop, is_rej;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign out_valid      = (occ_q != '0);
  assign out_ref        = mem_q[rd_ptr_q][191:96];
  assign out_nbr        = mem_q[rd_ptr_q][95:0];
  assign in_stall       = in_stall_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign accepted_count = acc_q;
  assign rejected_count = rej_q;
  assign overflow       = ovf_q;

  always_comb begin
    pop    = out_valid & out_ready;
    is_rej = in_pair[192];
    take   = (state_q == S_RUN) & in_valid;
    // A full FIFO still accepts when the head leaves in the same cycle.
    push   = take & ~is_rej & ((occ_q != FULL_C) | pop);
    drop   = take & ~is_rej & ~push;
    occ_d  = occ_q + OW'(push) - OW'(pop);

    state_d = state_q;
    acc_d   = acc_q;
    rej_d   = rej_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          acc_d   = '0;
          rej_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (push)          acc_d = sat_inc(acc_q);
        if (take & is_rej) rej_d = sat_inc(rej_q);
        if (drop)          ovf_d = 1'b1;
        if (flush)         state_d = S_DRAIN;
      end
      S_DRAIN: if (occ_d == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      occ_q      <= '0;
      in_stall_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      acc_q      <= '0;
      rej_q      <= '0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      in_stall_q <= (state_d == S_RUN) && (occ_d >= AF_C);
      busy_q     <= (state_d == S_RUN) || (state_d == S_DRAIN);
      done_q     <= (state_d == S_DONE);
      ovf_q      <= ovf_d;
      acc_q      <= acc_d;
      rej_q      <= rej_d;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and occupancy.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_pair[191:0];
  end

endmodule

// File: tb/tb_pair_queue.sv
// Directed bench for pair_queue: pass-through, rejection, full/back-pressure,
// full-with-pop, flush/drain and mid-run reset.
module tb_pair_queue;

  localparam int DEPTH = 16;
  localparam int AFM   = 4;
  localparam int CW    = 16;
  localparam logic [95:0] REF = 96'h3F800000_40000000_40400000;

  logic          clk = 1'b0;
  logic          rst, start, flush, in_valid, out_ready;
  logic [192:0]  in_pair;
  logic          in_stall, out_valid, busy, done, overflow;
  logic [95:0]   out_ref, out_nbr;
  logic [CW-1:0] accepted_count, rejected_count;

  int nvec = 0;
  int nerr = 0;

  pair_queue #(.DEPTH(DEPTH), .AF_MARGIN(AFM), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush),
    .in_pair(in_pair), .in_valid(in_valid), .in_stall(in_stall),
    .out_ref(out_ref), .out_nbr(out_nbr), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done),
    .accepted_count(accepted_count), .rejected_count(rejected_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs are applied before the edge and outputs sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pair(input logic rej, input logic [95:0] nbr);
    in_valid = 1'b1;
    in_pair  = {rej, REF, nbr};
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy", 192'(busy), 192'd1);
  endtask

  task automatic finish_ts();
    int n;
    in_valid  = 1'b0;
    flush     = 1'b1;
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      step();
      n++;
    end
    chk("done_seen", 192'(done), 192'd1);
    step();
    chk("done_pulse", 192'(done), 192'd0);
    chk("idle_busy", 192'(busy), 192'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; in_pair = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_valid", 192'(out_valid), 192'd0);
    chk("rst_stall", 192'(in_stall), 192'd0);
    chk("rst_busy", 192'(busy), 192'd0);
    chk("rst_done", 192'(done), 192'd0);
    chk("rst_ovf", 192'(overflow), 192'd0);
    chk("rst_acc", 192'(accepted_count), 192'd0);
    chk("rst_rej", 192'(rejected_count), 192'd0);

    // Basic pass-through with out_ready held high.
    do_start();
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      set_pair(1'b0, 96'(i));
      step();
      chk("pt_valid", 192'(out_valid), 192'd1);
      chk("pt_nbr", 192'(out_nbr), 192'(i));
      chk("pt_ref", 192'(out_ref), 192'(REF));
    end
    in_valid = 1'b0;
    step();
    chk("pt_empty", 192'(out_valid), 192'd0);
    chk("pt_acc", 192'(accepted_count), 192'd3);
    chk("pt_rej", 192'(rejected_count), 192'd0);
    finish_ts();
    chk("pt_acc_hold", 192'(accepted_count), 192'd3);

    // Rejection: reject = 1/0/1/0/1, pairs held in the FIFO.
    do_start();
    chk("rj_acc_clr", 192'(accepted_count), 192'd0);
    for (int i = 0; i < 5; i++) begin
      set_pair((i % 2) == 0, 96'(10 + i));
      step();
    end
    in_valid = 1'b0;
    chk("rj_head0", 192'(out_nbr), 192'd11);
    out_ready = 1'b1;
    step();
    chk("rj_head1", 192'(out_nbr), 192'd13);
    step();
    chk("rj_empty", 192'(out_valid), 192'd0);
    chk("rj_acc", 192'(accepted_count), 192'd2);
    chk("rj_rej", 192'(rejected_count), 192'd3);
    chk("rj_ovf", 192'(overflow), 192'd0);
    finish_ts();

    // Fill to full with no consumer; stall from the 12th push, 17th dropped.
    do_start();
    for (int k = 1; k <= 17; k++) begin
      set_pair(1'b0, 96'(100 + k));
      step();
      chk("ff_stall", 192'(in_stall), 192'((k >= DEPTH - AFM) ? 1 : 0));
      if (k == 16) chk("ff_ovf16", 192'(overflow), 192'd0);
    end
    in_valid = 1'b0;
    chk("ff_ovf17", 192'(overflow), 192'd1);
    chk("ff_acc", 192'(accepted_count), 192'd16);
    chk("ff_head", 192'(out_nbr), 192'd101);

    // Full with simultaneous pop: push accepted, occupancy stays at 16.
    set_pair(1'b0, 96'd200);
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("fp_acc", 192'(accepted_count), 192'd17);
    chk("fp_ovf", 192'(overflow), 192'd1);
    chk("fp_stall", 192'(in_stall), 192'd1);
    chk("fp_head", 192'(out_nbr), 192'd102);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fp_drain_stall", 192'(in_stall), 192'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("fp_order_v", 192'(out_valid), 192'd1);
      chk("fp_order", 192'(out_nbr), 192'((i < 15) ? 102 + i : 200));
      step();
    end
    chk("fp_done", 192'(done), 192'd1);
    chk("fp_empty", 192'(out_valid), 192'd0);
    step();
    chk("fp_idle", 192'(busy), 192'd0);
    out_ready = 1'b0;

    // Flush and drain: DRAIN input ignored, consumer stalled for 3 cycles.
    do_start();
    for (int i = 0; i < 4; i++) begin
      set_pair(1'b0, 96'(300 + i));
      step();
    end
    in_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    set_pair(1'b0, 96'd999);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fd_busy", 192'(busy), 192'd1);
      chk("fd_done", 192'(done), 192'd0);
      chk("fd_head", 192'(out_nbr), 192'd300);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("fd_order", 192'(out_nbr), 192'(300 + i));
      chk("fd_busy2", 192'(busy), 192'd1);
      step();
    end
    chk("fd_done1", 192'(done), 192'd1);
    chk("fd_empty", 192'(out_valid), 192'd0);
    step();
    chk("fd_done0", 192'(done), 192'd0);
    chk("fd_busy0", 192'(busy), 192'd0);
    chk("fd_acc", 192'(accepted_count), 192'd4);
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Reset mid-run with 6 entries queued.
    do_start();
    for (int i = 0; i < 6; i++) begin
      set_pair(1'b0, 96'(400 + i));
      step();
    end
    in_valid = 1'b0;
    chk("mr_acc6", 192'(accepted_count), 192'd6);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_valid", 192'(out_valid), 192'd0);
    chk("mr_acc", 192'(accepted_count), 192'd0);
    chk("mr_busy", 192'(busy), 192'd0);
    chk("mr_done", 192'(done), 192'd0);
    step();
    chk("mr_done2", 192'(done), 192'd0);
    do_start();
    set_pair(1'b0, 96'd500);
    step();
    in_valid = 1'b0;
    chk("mr_new_v", 192'(out_valid), 192'd1);
    chk("mr_new_nbr", 192'(out_nbr), 192'd500);
    chk("mr_new_acc", 192'(accepted_count), 192'd1);
    finish_ts();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
